// File: rtl/dp_ram_data_arbiter.sv
// dp_ram_data_arbiter: round-robin share of the RAM data port between the CPU (c_*) and debug (dbg_*) masters.
// Latency: ack 2 cycles after the request is sampled in IDLE, 1 cycle when out of window, TIMEOUT+2 on RAM timeout.
// Backpressure: one transaction in flight; a waiting master keeps access high until its own ack, nothing is dropped.
//
// Ports:
//    clk, rst                     clock, asynchronous active-high reset
//    c_access..c_wr_en            CPU request (held until c_ack); c_data/c_ack/c_error CPU response
//    dbg_access..dbg_wr_en        debug request (held until dbg_ack); dbg_data/dbg_ack/dbg_error response
//    ram_access..ram_wr_en        registered drive of the RAM data port (address is the window offset)
//    ram_data, ram_ack            RAM response, ack one cycle after ram_access && ram_cs
module dp_ram_data_arbiter #(
   parameter logic [31:0] RAM_BASE = 32'h0000_0000,
   parameter int unsigned RAM_SIZE = 4096,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_access,
   input  logic [31:0] c_addr,
   input  logic [3:0]  c_bytesel,
   input  logic [31:0] c_wr_val,
   input  logic        c_wr_en,
   output logic [31:0] c_data,
   output logic        c_ack,
   output logic        c_error,
   input  logic        dbg_access,
   input  logic [31:0] dbg_addr,
   input  logic [3:0]  dbg_bytesel,
   input  logic [31:0] dbg_wr_val,
   input  logic        dbg_wr_en,
   output logic [31:0] dbg_data,
   output logic        dbg_ack,
   output logic        dbg_error,
   output logic        ram_access,
   output logic        ram_cs,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_bytesel,
   output logic [31:0] ram_wr_val,
   output logic        ram_wr_en,
   input  logic [31:0] ram_data,
   input  logic        ram_ack
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

   // Window bounds widened to 33 bits so addr + 3 near 32'hFFFFFFFF cannot wrap into range.
   localparam logic [32:0] LP_WIN_LO = {1'b0, RAM_BASE};
   localparam logic [32:0] LP_WIN_HI = {1'b0, RAM_BASE} + 33'(RAM_SIZE);
   localparam logic [8:0]  LP_TMO    = 9'(TIMEOUT);

   state_t      r_state,       w_state_nxt;
   logic        r_grant_dbg,   w_grant_dbg_nxt;   // owner of the current transaction
   logic        r_last_dbg,    w_last_dbg_nxt;    // round-robin pointer: last granted master
   logic [7:0]  r_cnt,         w_cnt_nxt;
   logic        r_ram_access,  w_ram_access_nxt;
   logic        r_ram_cs,      w_ram_cs_nxt;
   logic [31:0] r_ram_addr,    w_ram_addr_nxt;
   logic [3:0]  r_ram_bytesel, w_ram_bytesel_nxt;
   logic [31:0] r_ram_wr_val,  w_ram_wr_val_nxt;
   logic        r_ram_wr_en,   w_ram_wr_en_nxt;

   logic        w_pick_dbg;
   logic [31:0] w_win_addr;
   logic        w_in_range;
   logic        w_wait_done;
   logic        w_err_done;

   // Debug wins when it is the only requester, or on a conflict when the CPU was granted last.
   assign w_pick_dbg = dbg_access && (!c_access || !r_last_dbg);
   assign w_win_addr = w_pick_dbg ? dbg_addr : c_addr;
   assign w_in_range = ({1'b0, w_win_addr} >= LP_WIN_LO) &&
                       (({1'b0, w_win_addr} + 33'd3) < LP_WIN_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_grant_dbg   <= 1'b0;
         r_last_dbg    <= 1'b1;  // so the CPU wins the first conflict after reset
         r_cnt         <= '0;
         r_ram_access  <= 1'b0;
         r_ram_cs      <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_bytesel <= '0;
         r_ram_wr_val  <= '0;
         r_ram_wr_en   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant_dbg   <= w_grant_dbg_nxt;
         r_last_dbg    <= w_last_dbg_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ram_access  <= w_ram_access_nxt;
         r_ram_cs      <= w_ram_cs_nxt;
         r_ram_addr    <= w_ram_addr_nxt;
         r_ram_bytesel <= w_ram_bytesel_nxt;
         r_ram_wr_val  <= w_ram_wr_val_nxt;
         r_ram_wr_en   <= w_ram_wr_en_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_dbg_nxt   = r_grant_dbg;
      w_last_dbg_nxt    = r_last_dbg;
      w_cnt_nxt         = r_cnt;
      w_ram_access_nxt  = r_ram_access;
      w_ram_cs_nxt      = r_ram_cs;
      w_ram_addr_nxt    = r_ram_addr;
      w_ram_bytesel_nxt = r_ram_bytesel;
      w_ram_wr_val_nxt  = r_ram_wr_val;
      w_ram_wr_en_nxt   = r_ram_wr_en;
      case (r_state)
         S_IDLE: begin
            if (c_access || dbg_access) begin
               w_grant_dbg_nxt = w_pick_dbg;
               w_last_dbg_nxt  = w_pick_dbg;
               if (w_in_range) begin
                  w_ram_access_nxt  = 1'b1;
                  w_ram_cs_nxt      = 1'b1;
                  w_ram_addr_nxt    = w_win_addr - RAM_BASE;
                  w_ram_bytesel_nxt = w_pick_dbg ? dbg_bytesel : c_bytesel;
                  w_ram_wr_val_nxt  = w_pick_dbg ? dbg_wr_val  : c_wr_val;
                  w_ram_wr_en_nxt   = w_pick_dbg ? dbg_wr_en   : c_wr_en;
                  w_state_nxt       = S_ISSUE;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_ISSUE: begin
            w_ram_access_nxt = 1'b0;
            w_ram_cs_nxt     = 1'b0;
            w_ram_wr_en_nxt  = 1'b0;
            w_cnt_nxt        = '0;
            w_state_nxt      = S_WAIT;
         end
         S_WAIT: begin
            if (ram_ack) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
               // Leaving after TIMEOUT WAIT cycles puts the error ack at N+TIMEOUT+2.
               if (({1'b0, r_cnt} + 9'd1) == LP_TMO) begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_ERR: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Responses are combinational so a RAM ack reaches the master in the same cycle.
   assign w_wait_done = (r_state == S_WAIT) && ram_ack;
   assign w_err_done  = (r_state == S_ERR);

   assign c_ack     = (w_wait_done || w_err_done) && !r_grant_dbg;
   assign c_error   = w_err_done && !r_grant_dbg;
   assign c_data    = (w_wait_done && !r_grant_dbg) ? ram_data : 32'h0;
   assign dbg_ack   = (w_wait_done || w_err_done) && r_grant_dbg;
   assign dbg_error = w_err_done && r_grant_dbg;
   assign dbg_data  = (w_wait_done && r_grant_dbg) ? ram_data : 32'h0;

   assign ram_access  = r_ram_access;
   assign ram_cs      = r_ram_cs;
   assign ram_addr    = r_ram_addr;
   assign ram_bytesel = r_ram_bytesel;
   assign ram_wr_val  = r_ram_wr_val;
   assign ram_wr_en   = r_ram_wr_en;

endmodule

// File: tb/tb_dp_ram_data_arbiter.sv
// tb_dp_ram_data_arbiter: drives the arbiter from both masters against a behavioural RAM.
// Latency: each master request is waited for with a bounded cycle budget.
// Backpressure: requests are held until the owning ack, as a well-behaved master would.
module tb_dp_ram_data_arbiter;

   localparam logic [31:0] RAM_BASE = 32'h0000_0000;
   localparam int unsigned RAM_SIZE = 4096;
   localparam int unsigned TIMEOUT  = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_access = 1'b0, dbg_access = 1'b0;
   logic [31:0] c_addr = '0, dbg_addr = '0, c_wr_val = '0, dbg_wr_val = '0;
   logic [3:0]  c_bytesel = '0, dbg_bytesel = '0;
   logic        c_wr_en = 1'b0, dbg_wr_en = 1'b0;
   logic [31:0] c_data, dbg_data;
   logic        c_ack, c_error, dbg_ack, dbg_error;
   logic        ram_access, ram_cs, ram_wr_en;
   logic [31:0] ram_addr, ram_wr_val;
   logic [3:0]  ram_bytesel;
   logic [31:0] ram_data = '0;
   logic        ram_ack = 1'b0;
   logic        mute = 1'b0;   // when set, the RAM never acknowledges

   logic [31:0] ram_mem [0:1023];   // behavioural RAM contents
   logic [31:0] ref_mem [0:1023];   // expected memory image
   bit          mdl_last;           // model: last granted master (1 = debug)
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   dp_ram_data_arbiter #(.RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .c_access(c_access), .c_addr(c_addr), .c_bytesel(c_bytesel), .c_wr_val(c_wr_val),
      .c_wr_en(c_wr_en), .c_data(c_data), .c_ack(c_ack), .c_error(c_error),
      .dbg_access(dbg_access), .dbg_addr(dbg_addr), .dbg_bytesel(dbg_bytesel),
      .dbg_wr_val(dbg_wr_val), .dbg_wr_en(dbg_wr_en), .dbg_data(dbg_data),
      .dbg_ack(dbg_ack), .dbg_error(dbg_error),
      .ram_access(ram_access), .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_bytesel(ram_bytesel),
      .ram_wr_val(ram_wr_val), .ram_wr_en(ram_wr_en), .ram_data(ram_data), .ram_ack(ram_ack)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] v,
                                         input logic [3:0] bs);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (bs[b]) w[8*b +: 8] = v[8*b +: 8];
      return w;
   endfunction

   function automatic bit in_window(input logic [31:0] a);
      longint unsigned la;
      la = longint'(a);
      return (la >= longint'(RAM_BASE)) && (la + 3 < longint'(RAM_BASE) + longint'(RAM_SIZE));
   endfunction

   function automatic logic [9:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - RAM_BASE;
      return off[11:2];
   endfunction

   // Behavioural RAM: one-cycle ack, byte-lane writes.
   always @(posedge clk) begin
      ram_ack <= ram_access && ram_cs && !mute;
      if (ram_access && ram_cs) begin
         if (ram_wr_en) ram_mem[ram_addr[11:2]] <= merge(ram_mem[ram_addr[11:2]], ram_wr_val, ram_bytesel);
         else           ram_data <= ram_mem[ram_addr[11:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {25'd0, ram_access, ram_cs, ram_wr_en, c_ack, c_error, dbg_ack, dbg_error}, 32'h0);
      chk({tag, "_dat"}, ram_addr | ram_wr_val | c_data | dbg_data, 32'h0);
      chk({tag, "_bs"}, {28'd0, ram_bytesel}, 32'h0);
   endtask

   // One transaction from master m (1 = debug); called at a negedge with the arbiter idle,
   // returns at the negedge where the arbiter is idle again.
   task automatic single(input bit m, input logic [31:0] a, input logic [3:0] bs,
                         input logic [31:0] v, input bit wr, output logic [31:0] od);
      bit inr, got, my_ack, my_err, ot_ack;
      int lat, pulses, exp_lat;
      logic [31:0] my_dat;
      inr = in_window(a);
      exp_lat = !inr ? 1 : 2;
      if (m) begin dbg_access = 1; dbg_addr = a; dbg_bytesel = bs; dbg_wr_val = v; dbg_wr_en = wr; end
      else   begin c_access = 1;   c_addr = a;   c_bytesel = bs;   c_wr_val = v;   c_wr_en = wr;   end
      lat = 0; pulses = 0; got = 0;
      my_ack = 0; my_err = 0; ot_ack = 0; my_dat = '0;
      while (!got && lat < int'(TIMEOUT) + 10) begin
         @(negedge clk);
         lat++;
         if (ram_access) begin
            pulses++;
            chk("ram_cs", {31'd0, ram_cs}, 32'd1);
            chk("ram_addr", ram_addr, a - RAM_BASE);
            chk("ram_bs", {28'd0, ram_bytesel}, {28'd0, bs});
            chk("ram_we", {31'd0, ram_wr_en}, {31'd0, wr});
            if (wr) chk("ram_wv", ram_wr_val, v);
         end
         my_ack = m ? dbg_ack : c_ack;
         my_err = m ? dbg_error : c_error;
         my_dat = m ? dbg_data : c_data;
         ot_ack = m ? (c_ack | c_error) : (dbg_ack | dbg_error);
         got = my_ack;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      chk("ack_lat", lat, exp_lat);
      chk("ack_err", {31'd0, my_err}, {31'd0, !inr});
      chk("other_idle", {31'd0, ot_ack}, 32'd0);
      chk("ram_pulses", pulses, inr ? 1 : 0);
      if (inr) chk("we_drop", {31'd0, ram_wr_en}, 32'd0);
      if (!inr) chk("err_data", my_dat, 32'h0);
      else if (!wr) chk("rd_data", my_dat, ref_mem[widx(a)]);
      od = my_dat;
      if (m) dbg_access = 0; else c_access = 0;
      if (inr && wr) ref_mem[widx(a)] = merge(ref_mem[widx(a)], v, bs);
      mdl_last = m;
      @(negedge clk);
   endtask

   // Both masters read continuously; grants must alternate starting from the model's pick.
   task automatic contend(input int n, input logic [31:0] ca, input logic [31:0] da);
      int lat, k;
      bit exp_w, who;
      c_access = 1; c_addr = ca; c_wr_en = 0; c_bytesel = 4'hF;
      dbg_access = 1; dbg_addr = da; dbg_wr_en = 0; dbg_bytesel = 4'hF;
      exp_w = !mdl_last;
      lat = 0; k = 0;
      while (k < n && lat < 3 * n + 10) begin
         @(negedge clk);
         lat++;
         if (c_ack && dbg_ack) chk("dual_ack", 32'd1, 32'd0);
         if (c_ack || dbg_ack) begin
            who = dbg_ack;
            chk("rr_order", {31'd0, who}, {31'd0, exp_w});
            chk("rr_lat", lat, 2 + 3 * k);
            chk("rr_err", {31'd0, who ? dbg_error : c_error}, 32'd0);
            chk("rr_data", who ? dbg_data : c_data, ref_mem[widx(who ? da : ca)]);
            mdl_last = who;
            exp_w = !who;
            k++;
            if (k == n) begin c_access = 0; dbg_access = 0; end
         end
      end
      chk("rr_count", k, n);
      c_access = 0; dbg_access = 0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat;
      bit got, c_seen;
      logic [31:0] od;
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      mdl_last = 1'b1;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      rst = 0;

      // Continuous contention straight out of reset: CPU first, then strict alternation.
      ram_mem[2] = 32'hC0C0_0008; ref_mem[2] = 32'hC0C0_0008;
      ram_mem[3] = 32'hD0D0_000C; ref_mem[3] = 32'hD0D0_000C;
      contend(6, 32'h8, 32'hC);

      // Full-word write then read back.
      single(0, 32'h10, 4'hF, 32'hDEADBEEF, 1, od);
      single(0, 32'h10, 4'hF, 32'h0, 0, od);
      chk("rd_deadbeef", od, 32'hDEADBEEF);

      // Single-lane write into a preloaded word.
      ram_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
      single(0, 32'h20, 4'b0100, 32'h00AA0000, 1, od);
      single(0, 32'h20, 4'hF, 32'h0, 0, od);
      chk("byte_merge", od, 32'h11AA3344);

      // Window edges.
      single(1, RAM_BASE + RAM_SIZE, 4'hF, 32'h0, 0, od);
      single(1, RAM_BASE + RAM_SIZE - 4, 4'hF, 32'h55AA_55AA, 1, od);
      single(0, RAM_BASE + RAM_SIZE - 4, 4'hF, 32'h0, 0, od);
      chk("top_word", od, 32'h55AA_55AA);
      single(0, RAM_BASE + RAM_SIZE - 3, 4'hF, 32'h0, 0, od);
      single(1, 32'hFFFF_FFFC, 4'hF, 32'h0, 0, od);

      // Randomized single transactions.
      for (int i = 0; i < 40; i++) begin
         int r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         if (r == 0)      a = RAM_BASE + RAM_SIZE + $urandom_range(0, 64);
         else if (r == 1) a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         else             a = RAM_BASE + $urandom_range(0, 31) * 4;
         single(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom,
                1'($urandom_range(0, 1)), od);
      end

      // RAM silent: debug read times out while a CPU read queues behind it.
      mute = 1;
      dbg_access = 1; dbg_addr = 32'h40; dbg_wr_en = 0; dbg_bytesel = 4'hF;
      lat = 0; got = 0; c_seen = 0;
      while (!got && lat < int'(TIMEOUT) + 10) begin
         @(negedge clk);
         lat++;
         if (lat == 4) begin c_access = 1; c_addr = 32'h10; c_wr_en = 0; c_bytesel = 4'hF; end
         if (c_ack) c_seen = 1;
         got = dbg_ack;
      end
      chk("to_seen", {31'd0, got}, 32'd1);
      chk("to_lat", lat, TIMEOUT + 2);
      chk("to_err", {31'd0, dbg_error}, 32'd1);
      chk("to_data", dbg_data, 32'h0);
      chk("to_c_early", {31'd0, c_seen}, 32'd0);
      dbg_access = 0; mute = 0;
      lat = 0; got = 0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         got = c_ack;
      end
      chk("q_lat", lat, 3);
      chk("q_err", {31'd0, c_error}, 32'd0);
      chk("q_data", c_data, 32'hDEADBEEF);
      c_access = 0;
      @(negedge clk);

      // Reset in the middle of a waiting CPU read.
      mute = 1;
      c_access = 1; c_addr = 32'h10; c_wr_en = 0; c_bytesel = 4'hF;
      repeat (3) @(negedge clk);
      chk("pre_rst_ack", {31'd0, c_ack}, 32'd0);
      rst = 1; c_access = 0;
      #1;
      chk_quiet("mid_rst");
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_ack", {30'd0, c_ack, dbg_ack}, 32'd0);
      end
      rst = 0; mute = 0; mdl_last = 1'b1;
      contend(2, 32'h10, 32'h8);
      single(0, 32'h20, 4'hF, 32'h0, 0, od);
      chk("post_rst_rd", od, 32'h11AA3344);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
